// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared register-file sizing and grant encoding used across the writeback slice.
package regfile_wb_arbiter_pkg;
    localparam int DATA_BUS_WIDTH_D    = 16;
    localparam int REGFILE_ADDR_BITS_D = 4;
    localparam int NUM_REGISTERS_D     = 1 << REGFILE_ADDR_BITS_D;
    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback requesters, decode issue, hazard query and register file write port.
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DW = DATA_BUS_WIDTH_D,
    parameter int AW = REGFILE_ADDR_BITS_D
);
    logic          a_valid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic          a_ready;
    logic          b_valid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;
    logic          b_ready;
    logic          issue_valid;
    logic [AW-1:0] issue_addr;
    logic          issue_ready;
    logic [AW-1:0] rd_addr1;
    logic [AW-1:0] rd_addr2;
    logic          hazard1;
    logic          hazard2;
    logic          wr_enable;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
               issue_valid, issue_addr, rd_addr1, rd_addr2,
        input  a_ready, b_ready, issue_ready, hazard1, hazard2,
               wr_enable, wr_addr, wr_data
    );
    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
               issue_valid, issue_addr, rd_addr1, rd_addr2,
        output a_ready, b_ready, issue_ready, hazard1, hazard2,
               wr_enable, wr_addr, wr_data
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits set by issue, cleared by writeback, plus read hazard detection.
module regfile_scoreboard
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int REGFILE_ADDR_BITS = REGFILE_ADDR_BITS_D,
    parameter int NUM_REGISTERS     = NUM_REGISTERS_D
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         set_en,
    input  logic [REGFILE_ADDR_BITS-1:0] set_addr,
    input  logic                         clr_en,
    input  logic [REGFILE_ADDR_BITS-1:0] clr_addr,
    input  logic [REGFILE_ADDR_BITS-1:0] issue_addr,
    input  logic [REGFILE_ADDR_BITS-1:0] rd_addr1,
    input  logic [REGFILE_ADDR_BITS-1:0] rd_addr2,
    input  logic                         wr_enable,
    input  logic [REGFILE_ADDR_BITS-1:0] wr_addr,
    output logic                         issue_ok,
    output logic                         hazard1,
    output logic                         hazard2
);
    logic [NUM_REGISTERS-1:0] busy, set_vec, clr_vec;
    assign set_vec = set_en ? NUM_REGISTERS'(1) << set_addr : '0;
    assign clr_vec = clr_en ? NUM_REGISTERS'(1) << clr_addr : '0;
    // set is ORed in after the clear so a same-cycle reservation survives; bit 0 is masked off
    always_ff @(posedge clk) begin
        busy <= rst ? '0 : (set_vec | (busy & ~clr_vec)) & ~NUM_REGISTERS'(1);
    end
    assign issue_ok = !busy[issue_addr] || issue_addr == '0;
    // the write still in flight to the register file counts as a hazard until it commits
    assign hazard1  = rd_addr1 != '0 && (busy[rd_addr1] || (wr_enable && wr_addr == rd_addr1));
    assign hazard2  = rd_addr2 != '0 && (busy[rd_addr2] || (wr_enable && wr_addr == rd_addr2));
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbitration of ALU/memory writebacks into a registered register file
// write port, with a destination scoreboard for decode.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_BUS_WIDTH    = DATA_BUS_WIDTH_D,
    parameter int REGFILE_ADDR_BITS = REGFILE_ADDR_BITS_D,
    parameter int NUM_REGISTERS     = NUM_REGISTERS_D
) (
    input logic                clk,
    input logic                rst,
    regfile_wb_arbiter_if.slave bus
);
    grant_e                       last_grant;
    logic                         a_fire, b_fire, fire, issue_ok, wr_enable_q;
    logic [REGFILE_ADDR_BITS-1:0] win_addr, wr_addr_q;
    logic [DATA_BUS_WIDTH-1:0]    win_data, wr_data_q;
    assign bus.a_ready = !rst && bus.a_valid && (!bus.b_valid || last_grant == GRANT_B);
    assign bus.b_ready = !rst && bus.b_valid && (!bus.a_valid || last_grant == GRANT_A);
    assign bus.issue_ready = !rst && issue_ok;
    assign a_fire   = bus.a_valid && bus.a_ready;
    assign b_fire   = bus.b_valid && bus.b_ready;
    assign fire     = a_fire || b_fire;
    assign win_addr = a_fire ? bus.a_addr : bus.b_addr;
    assign win_data = a_fire ? bus.a_data : bus.b_data;
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant  <= GRANT_B;
            wr_enable_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            wr_enable_q <= fire && win_addr != '0;
            if (fire) begin
                last_grant <= b_fire ? GRANT_B : GRANT_A;
                wr_addr_q  <= win_addr;
                wr_data_q  <= win_data;
            end
        end
    end
    assign bus.wr_enable = wr_enable_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    regfile_scoreboard #(
        .REGFILE_ADDR_BITS(REGFILE_ADDR_BITS),
        .NUM_REGISTERS    (NUM_REGISTERS)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_en    (bus.issue_valid && bus.issue_ready && bus.issue_addr != '0),
        .set_addr  (bus.issue_addr),
        .clr_en    (fire),
        .clr_addr  (win_addr),
        .issue_addr(bus.issue_addr),
        .rd_addr1  (bus.rd_addr1),
        .rd_addr2  (bus.rd_addr2),
        .wr_enable (wr_enable_q),
        .wr_addr   (wr_addr_q),
        .issue_ok  (issue_ok),
        .hazard1   (bus.hazard1),
        .hazard2   (bus.hazard2)
    );
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed writeback arbitration, scoreboard and reset scenarios with fixed expectations.
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [15:0] rf [16];
    regfile_wb_arbiter_if bus ();
    regfile_wb_arbiter dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    // register file model commits on the negedge of the wr_enable cycle
    always @(negedge clk) if (bus.wr_enable) rf[bus.wr_addr] <= bus.wr_data;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic settle();
        #1;
    endtask
    initial begin
        for (int i = 0; i < 16; i++) rf[i] = '0;
        bus.a_valid = 0; bus.a_addr = 0; bus.a_data = 0;
        bus.b_valid = 0; bus.b_addr = 0; bus.b_data = 0;
        bus.issue_valid = 0; bus.issue_addr = 0;
        bus.rd_addr1 = 0; bus.rd_addr2 = 0;
        step();
        step();
        rst = 0;
        bus.rd_addr1 = 3;
        settle();
        check("rst_wr_enable", bus.wr_enable, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_hazard1", bus.hazard1, 0);
        bus.a_valid = 1; bus.a_addr = 3; bus.a_data = 16'h1111;
        bus.b_valid = 1; bus.b_addr = 5; bus.b_data = 16'h2222;
        settle();
        check("rr0_a_ready", bus.a_ready, 1);
        check("rr0_b_ready", bus.b_ready, 0);
        step();
        check("rr1_wr_enable", bus.wr_enable, 1);
        check("rr1_wr_addr", bus.wr_addr, 3);
        check("rr1_wr_data", bus.wr_data, 16'h1111);
        check("rr1_inflight_hazard", bus.hazard1, 1);
        check("rr1_a_ready", bus.a_ready, 0);
        check("rr1_b_ready", bus.b_ready, 1);
        step();
        check("rr2_wr_enable", bus.wr_enable, 1);
        check("rr2_wr_addr", bus.wr_addr, 5);
        check("rr2_wr_data", bus.wr_data, 16'h2222);
        check("rr2_a_ready", bus.a_ready, 1);
        step();
        check("rr3_wr_enable", bus.wr_enable, 1);
        check("rr3_wr_addr", bus.wr_addr, 3);
        bus.a_valid = 0; bus.b_valid = 0;
        step();
        check("idle_wr_enable", bus.wr_enable, 0);
        check("idle_wr_addr", bus.wr_addr, 3);
        check("idle_wr_data", bus.wr_data, 16'h1111);
        check("idle_hazard1", bus.hazard1, 0);
        check("idle_rf3", rf[3], 16'h1111);
        check("idle_rf5", rf[5], 16'h2222);
        bus.issue_valid = 1; bus.issue_addr = 7; bus.rd_addr1 = 7;
        settle();
        check("iss7_ready", bus.issue_ready, 1);
        check("iss7_hazard_before", bus.hazard1, 0);
        step();
        check("iss7_hazard", bus.hazard1, 1);
        check("iss7_second_ready", bus.issue_ready, 0);
        step();
        bus.issue_valid = 0;
        bus.a_valid = 1; bus.a_addr = 7; bus.a_data = 16'hBEEF;
        settle();
        check("wb7_a_ready", bus.a_ready, 1);
        check("wb7_hazard_pre", bus.hazard1, 1);
        step();
        bus.a_valid = 0;
        settle();
        check("wb7_wr_enable", bus.wr_enable, 1);
        check("wb7_hazard_wr", bus.hazard1, 1);
        check("wb7_issue_ready", bus.issue_ready, 1);
        step();
        check("wb7_hazard_after", bus.hazard1, 0);
        check("wb7_rf7", rf[7], 16'hBEEF);
        bus.a_valid = 1; bus.a_addr = 0; bus.a_data = 16'hFFFF;
        bus.issue_valid = 1; bus.issue_addr = 0;
        bus.rd_addr1 = 0; bus.rd_addr2 = 0;
        settle();
        check("z_a_ready", bus.a_ready, 1);
        check("z_issue_ready", bus.issue_ready, 1);
        check("z_hazard1", bus.hazard1, 0);
        step();
        check("z_wr_enable", bus.wr_enable, 0);
        check("z_wr_addr", bus.wr_addr, 0);
        check("z_wr_data", bus.wr_data, 16'hFFFF);
        check("z_hazard1_post", bus.hazard1, 0);
        check("z_hazard2_post", bus.hazard2, 0);
        check("z_issue_ready_post", bus.issue_ready, 1);
        bus.a_valid = 0;
        bus.issue_addr = 4;
        bus.b_valid = 1; bus.b_addr = 4; bus.b_data = 16'h4444;
        bus.rd_addr2 = 4;
        settle();
        check("sw_issue_ready", bus.issue_ready, 1);
        check("sw_b_ready", bus.b_ready, 1);
        check("sw_hazard2_pre", bus.hazard2, 0);
        step();
        bus.issue_valid = 0; bus.b_valid = 0;
        settle();
        check("sw_wr_addr", bus.wr_addr, 4);
        check("sw_hazard2", bus.hazard2, 1);
        step();
        check("sw_busy_kept", bus.hazard2, 1);
        check("sw_wr_enable", bus.wr_enable, 0);
        check("sw_issue_blocked", bus.issue_ready, 0);
        bus.issue_valid = 1; bus.issue_addr = 2; bus.rd_addr1 = 2;
        step();
        check("r_busy2", bus.hazard1, 1);
        bus.a_valid = 1; bus.a_addr = 3; bus.a_data = 16'h3333;
        bus.b_valid = 1; bus.b_addr = 5; bus.b_data = 16'h5555;
        rst = 1;
        settle();
        check("r_a_ready", bus.a_ready, 0);
        check("r_b_ready", bus.b_ready, 0);
        check("r_issue_ready", bus.issue_ready, 0);
        step();
        bus.issue_valid = 0;
        settle();
        check("r_wr_enable", bus.wr_enable, 0);
        check("r_wr_addr", bus.wr_addr, 0);
        check("r_wr_data", bus.wr_data, 0);
        check("r_hazard1", bus.hazard1, 0);
        check("r_hazard2", bus.hazard2, 0);
        rst = 0;
        settle();
        check("r_first_a_ready", bus.a_ready, 1);
        check("r_first_b_ready", bus.b_ready, 0);
        step();
        check("r_first_wr_addr", bus.wr_addr, 3);
        check("r_first_wr_data", bus.wr_data, 16'h3333);
        bus.a_valid = 0; bus.b_valid = 0;
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
